// File: rtl/pc_defs.sv
// rtl/pc_defs.sv - shared constants and FSM state encoding for the fetch PC generator
package pc_defs;

   localparam logic RstEnable   = 1'b1;
   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;
   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   typedef logic [1:0] pc_state_t;

   localparam pc_state_t BOOT = 2'd0;
   localparam pc_state_t RUN  = 2'd1;
   localparam pc_state_t HALT = 2'd2;

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch-side handshake and redirect bundle between pc_gen and its environment
interface pc_gen_if #(
   parameter int ADDR_W = 32
);

   logic              stall;
   logic              br_valid;
   logic [ADDR_W-1:0] br_target;
   logic              if_ready;
   logic [ADDR_W-1:0] pc;
   logic              ce;
   logic              if_valid;
   logic              misalign;

   modport master (
      input  stall, br_valid, br_target, if_ready,
      output pc, ce, if_valid, misalign
   );

   modport slave (
      output stall, br_valid, br_target, if_ready,
      input  pc, ce, if_valid, misalign
   );

endinterface

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - single-entry holding register for a redirect that arrives while stalled
module pc_redirect_buf #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic [ADDR_W-1:0] capture_target,
   input  logic              clear,
   output logic              pend_valid,
   output logic [ADDR_W-1:0] pend_target
);

   import pc_defs::*;

   // A newer capture always overwrites the older entry
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         pend_valid  <= 1'b0;
         pend_target <= '0;
      end else if (capture) begin
         pend_valid  <= 1'b1;
         pend_target <= capture_target;
      end else if (clear) begin
         pend_valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program counter with stall, buffered redirect and misalignment halt
module pc_gen #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
   parameter int                STEP       = 4,
   parameter int                ALIGN_BITS = 2
) (
   input  logic     clk,
   input  logic     rst,
   pc_gen_if.master bus
);

   import pc_defs::*;

   // Zero-width mask when ALIGN_BITS is 0, which disables the check
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

   pc_state_t         state_q;
   logic [ADDR_W-1:0] pc_q;
   logic              ce_q;
   logic              misalign_q;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_target;
   logic              buf_capture;
   logic              buf_clear;
   logic              br_misaligned;
   logic              if_valid;
   logic              fire;

   assign br_misaligned = |(bus.br_target & ALIGN_MASK);
   assign if_valid      = (state_q == RUN) & ~bus.stall & ~pend_valid;
   assign fire          = if_valid & bus.if_ready;

   always_comb begin
      buf_capture = 1'b0;
      buf_clear   = 1'b0;
      if (state_q == BOOT) begin
         buf_capture = bus.br_valid;
      end else if (state_q == RUN) begin
         if (bus.br_valid && !br_misaligned) begin
            buf_capture = bus.stall;
            buf_clear   = ~bus.stall;
         end else if (!bus.br_valid && pend_valid && !bus.stall) begin
            buf_clear = 1'b1;
         end
      end
   end

   pc_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
      .clk            (clk),
      .rst            (rst),
      .capture        (buf_capture),
      .capture_target (bus.br_target),
      .clear          (buf_clear),
      .pend_valid     (pend_valid),
      .pend_target    (pend_target)
   );

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q    <= BOOT;
         pc_q       <= RESET_VEC;
         ce_q       <= ChipDisable;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         case (state_q)
            BOOT: begin
               ce_q    <= ChipEnable;
               state_q <= RUN;
            end
            RUN: begin
               // A redirect always beats sequential advance, even on an accepted fetch
               if (bus.br_valid && br_misaligned) begin
                  misalign_q <= 1'b1;
                  ce_q       <= ChipDisable;
                  state_q    <= HALT;
               end else if (bus.br_valid && !bus.stall) begin
                  pc_q <= bus.br_target;
               end else if (bus.br_valid) begin
                  pc_q <= pc_q;
               end else if (pend_valid && !bus.stall) begin
                  pc_q <= pend_target;
               end else if (fire) begin
                  pc_q <= pc_q + ADDR_W'(STEP);
               end
            end
            default: begin
               ce_q <= ChipDisable;
            end
         endcase
      end
   end

   assign bus.pc       = pc_q;
   assign bus.ce       = ce_q;
   assign bus.if_valid = if_valid;
   assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen (32-bit and 8-bit wrap instances)
module tb_pc_gen;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   n_checks = 0;
   int   n_fails  = 0;

   always #5 clk = ~clk;

   pc_gen_if #(.ADDR_W(32)) ia ();
   pc_gen_if #(.ADDR_W(8))  ib ();

   pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .STEP(4), .ALIGN_BITS(2)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (ia.master)
   );

   pc_gen #(.ADDR_W(8), .RESET_VEC(8'hF8), .STEP(4), .ALIGN_BITS(2)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (ib.master)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      ia.stall = 1'b0; ia.br_valid = 1'b0; ia.br_target = '0; ia.if_ready = 1'b1;
      ib.stall = 1'b0; ib.br_valid = 1'b0; ib.br_target = '0; ib.if_ready = 1'b0;

      // reset, boot and sequential advance
      tick();
      tick();
      chk("rst_ce", 32'(ia.ce), 32'h0);
      chk("rst_pc", ia.pc, 32'h0);
      chk("rst_ifv", 32'(ia.if_valid), 32'h0);
      chk("rst_mis", 32'(ia.misalign), 32'h0);
      rst_a = 1'b0;
      tick();
      chk("boot_ce", 32'(ia.ce), 32'h1);
      chk("boot_pc", ia.pc, 32'h0);
      chk("boot_ifv", 32'(ia.if_valid), 32'h1);
      tick();
      chk("seq_pc4", ia.pc, 32'h4);
      tick();
      chk("seq_pc8", ia.pc, 32'h8);
      tick();
      chk("seq_pc12", ia.pc, 32'hC);
      tick();
      chk("seq_pc16", ia.pc, 32'h10);

      // fetch unit not ready holds pc with a valid request
      ia.if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_pc", ia.pc, 32'h10);
         chk("hold_ifv", 32'(ia.if_valid), 32'h1);
      end
      ia.if_ready = 1'b1;
      tick();
      chk("ready_pc", ia.pc, 32'h14);

      // redirect beats an accepted fetch
      ia.br_valid = 1'b1; ia.br_target = 32'h100;
      tick();
      chk("br_pc", ia.pc, 32'h100);

      // redirects during stall: newest one wins
      ia.stall = 1'b1; ia.br_target = 32'h200;
      tick();
      chk("stall_br1_pc", ia.pc, 32'h100);
      chk("stall_ifv", 32'(ia.if_valid), 32'h0);
      ia.br_target = 32'h300;
      tick();
      chk("stall_br2_pc", ia.pc, 32'h100);
      ia.br_valid = 1'b0;
      ia.stall = 1'b0;
      #1;
      chk("pend_ifv", 32'(ia.if_valid), 32'h0);
      tick();
      chk("pend_pc", ia.pc, 32'h300);
      chk("pend_done_ifv", 32'(ia.if_valid), 32'h1);
      tick();
      chk("after_pend_pc", ia.pc, 32'h304);

      // misaligned target halts until reset
      ia.br_valid = 1'b1; ia.br_target = 32'h102;
      tick();
      chk("mis_pulse", 32'(ia.misalign), 32'h1);
      chk("mis_ce", 32'(ia.ce), 32'h0);
      chk("mis_pc", ia.pc, 32'h304);
      chk("mis_ifv", 32'(ia.if_valid), 32'h0);
      ia.br_target = 32'h400;
      tick();
      chk("halt_mis_clr", 32'(ia.misalign), 32'h0);
      chk("halt_pc", ia.pc, 32'h304);
      ia.br_valid = 1'b0;
      tick();
      chk("halt_pc2", ia.pc, 32'h304);
      chk("halt_ce", 32'(ia.ce), 32'h0);
      rst_a = 1'b1;
      tick();
      chk("halt_rst_pc", ia.pc, 32'h0);
      chk("halt_rst_ce", 32'(ia.ce), 32'h0);
      rst_a = 1'b0;
      tick();
      chk("halt_reboot_ce", 32'(ia.ce), 32'h1);

      // 8-bit instance: wraparound and reset with a pending redirect
      ib.if_ready = 1'b1;
      rst_b = 1'b0;
      tick();
      chk("b_boot_pc", 32'(ib.pc), 32'hF8);
      chk("b_boot_ce", 32'(ib.ce), 32'h1);
      tick();
      chk("b_pc_fc", 32'(ib.pc), 32'hFC);
      tick();
      chk("b_pc_wrap", 32'(ib.pc), 32'h00);
      tick();
      chk("b_pc_04", 32'(ib.pc), 32'h04);
      ib.stall = 1'b1; ib.br_valid = 1'b1; ib.br_target = 8'h40;
      tick();
      chk("b_stall_pc", 32'(ib.pc), 32'h04);
      ib.br_valid = 1'b0;
      rst_b = 1'b1;
      tick();
      chk("b_rst_pc", 32'(ib.pc), 32'hF8);
      chk("b_rst_ce", 32'(ib.ce), 32'h0);
      rst_b = 1'b0;
      ib.stall = 1'b0;
      tick();
      chk("b_reboot_ifv", 32'(ib.if_valid), 32'h1);
      tick();
      chk("b_no_pend_pc", 32'(ib.pc), 32'hFC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
